// File: rtl/dmem_responder_pkg.sv
// Shared types for the data-memory responder: word type, FSM state
// encodings and the latched request record.
package dmem_responder_pkg;

    typedef logic [31:0] word_t;

    // FSM state encodings kept as plain constants so older code that
    // compares raw 2-bit state values keeps working.
    typedef logic [1:0] dmem_state_t;
    localparam dmem_state_t IDLE = 2'd0;
    localparam dmem_state_t WAIT = 2'd1;
    localparam dmem_state_t RESP = 2'd2;

    // Everything the responder needs to remember once a request is accepted;
    // the initiator is free to change its inputs after the accept cycle.
    typedef struct packed {
        word_t      addr;
        word_t      wdata;
        logic       is_write;
        logic [3:0] wstrb;
    } dmem_req_t;

endpackage

// File: rtl/dmem_responder_ram_array.sv
// Word-wide backing store for the data-memory responder.
// Synchronous write with per-byte enables, asynchronous read.
// Contents are never reset.
module dmem_ram_array
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic                           clk,
    input  logic                           we_i,
    input  logic [3:0]                     be_i,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr_i,
    input  word_t                          wdata_i,
    output word_t                          rdata_o
);

    word_t mem [DEPTH_WORDS];

    // Commit only the byte lanes whose enable is set.
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign rdata_o = mem[addr_i];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the MIPS data port with an addr_ok/data_ok
// handshake. One request in flight, LATENCY cycles from accept to response,
// misaligned and out-of-window accesses are flagged with addr_err.
// Optional feature: define DMEM_BYTE_STROBE_EN to add the dmem_wstrb port
// and honour per-byte write enables; otherwise every write is a full word.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] dmem_addr,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [31:0] dmem_wdata,
`ifdef DMEM_BYTE_STROBE_EN
    input  logic [3:0]  dmem_wstrb,
`endif
    output logic [31:0] dmem_rdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic        addr_err
);

    localparam int    AW           = $clog2(DEPTH_WORDS);
    localparam word_t WINDOW_BYTES = word_t'(4 * DEPTH_WORDS);
    localparam logic [3:0] LAT_START = 4'(LATENCY - 1);

    dmem_state_t state_q, state_d;
    logic [3:0]  count_q, count_d;
    dmem_req_t   req_q, req_d;

    logic          inResp;
    logic          misaligned;
    logic          outOfWindow;
    logic          isFault;
    word_t         offsetBytes;
    logic [AW-1:0] ramIndex;
    logic          ramWe;
    word_t         ramRdata;

    // Next-state logic: accept in IDLE, count down in WAIT, single RESP cycle.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        req_d   = req_q;
        case (state_q)
            IDLE: begin
                if (memread || memwrite) begin
                    req_d.addr     = dmem_addr;
                    req_d.wdata    = dmem_wdata;
                    req_d.is_write = memwrite;
`ifdef DMEM_BYTE_STROBE_EN
                    req_d.wstrb    = dmem_wstrb;
`else
                    req_d.wstrb    = 4'b1111;
`endif
                    if (LATENCY == 1) begin
                        state_d = RESP;
                        count_d = 4'd0;
                    end else begin
                        state_d = WAIT;
                        count_d = LAT_START;
                    end
                end
            end
            WAIT: begin
                count_d = count_q - 4'd1;
                if (count_q == 4'd1) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
                count_d = 4'd0;
            end
            default: begin
                state_d = IDLE;
                count_d = 4'd0;
            end
        endcase
    end

    // State, counter and latched request; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            count_q <= 4'd0;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            req_q   <= req_d;
        end
    end

    // Fault check on the latched address; the subtraction wraps so addresses
    // below the base land far outside the window.
    always_comb begin
        offsetBytes = req_q.addr - BASE_ADDR;
        misaligned  = (req_q.addr[1:0] != 2'b00);
        outOfWindow = (offsetBytes >= WINDOW_BYTES);
        isFault     = misaligned || outOfWindow;
        ramIndex    = offsetBytes[AW+1:2];
    end

    assign inResp = (state_q == RESP);

    // A reset arriving on the RESP edge must not let the write through.
    assign ramWe = inResp && req_q.is_write && !isFault && resetn;

    dmem_ram_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_ram (
        .clk    (clk),
        .we_i   (ramWe),
        .be_i   (req_q.wstrb),
        .addr_i (ramIndex),
        .wdata_i(req_q.wdata),
        .rdata_o(ramRdata)
    );

    assign addr_ok    = (state_q == IDLE);
    assign data_ok    = inResp;
    assign addr_err   = inResp && isFault;
    assign dmem_rdata = (inResp && !req_q.is_write && !isFault) ? ramRdata : 32'h0;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder. Two instances run side by side,
// one with LATENCY=2 and one with LATENCY=1. Expected responses are queued
// when a request is driven and compared when data_ok appears.
module tb_dmem_responder;

    localparam logic [31:0] BASE = 32'h8000_0000;

    typedef struct {
        int          acceptCyc;
        int          respCyc;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    int   cyc = 0;
    bit   monEn = 1'b0;
    int   total = 0;
    int   bad = 0;

    logic        rstn2, rd2, wr2, aok2, dok2, aerr2;
    logic [31:0] addr2, wd2, rdata2;
    logic        rstn1, rd1, wr1, aok1, dok1, aerr1;
    logic [31:0] addr1, wd1, rdata1;
`ifdef DMEM_BYTE_STROBE_EN
    logic [3:0]  strb2, strb1;
`endif

    exp_t        q2[$];
    exp_t        q1[$];
    logic [31:0] m2[int];
    logic [31:0] m1[int];

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2), .BASE_ADDR(BASE)) u_dut2 (
        .clk(clk), .resetn(rstn2), .dmem_addr(addr2), .memread(rd2), .memwrite(wr2),
        .dmem_wdata(wd2),
`ifdef DMEM_BYTE_STROBE_EN
        .dmem_wstrb(strb2),
`endif
        .dmem_rdata(rdata2), .addr_ok(aok2), .data_ok(dok2), .addr_err(aerr2)
    );

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(1), .BASE_ADDR(BASE)) u_dut1 (
        .clk(clk), .resetn(rstn1), .dmem_addr(addr1), .memread(rd1), .memwrite(wr1),
        .dmem_wdata(wd1),
`ifdef DMEM_BYTE_STROBE_EN
        .dmem_wstrb(strb1),
`endif
        .dmem_rdata(rdata1), .addr_ok(aok1), .data_ok(dok1), .addr_err(aerr1)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Cycle index; a request presented while cyc==t is accepted on the edge ending t.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit badAddr(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return (a[1:0] != 2'b00) || (off >= 32'd4096);
    endfunction

    // Per-cycle response checker for one instance.
    task automatic monitorStep(input int sel, input logic dOk, input logic aOk,
                               input logic aErr, input logic [31:0] rd);
        exp_t e;
        bit   have;
        have = (sel == 2) ? (q2.size() > 0) : (q1.size() > 0);
        if (have) e = (sel == 2) ? q2[0] : q1[0];
        if (have && cyc > e.acceptCyc && cyc <= e.respCyc)
            checkOutput($sformatf("busy%0d", sel), {31'b0, aOk}, 32'd0);
        if (dOk) begin
            if (!have) begin
                checkOutput($sformatf("stray%0d", sel), 32'd1, 32'd0);
            end else begin
                checkOutput($sformatf("when%0d", sel), cyc, e.respCyc);
                checkOutput($sformatf("err%0d", sel), {31'b0, aErr}, {31'b0, e.err});
                checkOutput($sformatf("rdata%0d", sel), rd, e.rdata);
                if (sel == 2) void'(q2.pop_front()); else void'(q1.pop_front());
            end
        end else begin
            checkOutput($sformatf("idleErr%0d", sel), {31'b0, aErr}, 32'd0);
            checkOutput($sformatf("idleRdata%0d", sel), rd, 32'd0);
            if (have && cyc >= e.respCyc) begin
                checkOutput($sformatf("missed%0d", sel), cyc, e.respCyc);
                if (sel == 2) void'(q2.pop_front()); else void'(q1.pop_front());
            end
        end
    endtask

    // Sample outputs on the falling edge, away from the active edge.
    always @(negedge clk) if (monEn) monitorStep(2, dok2, aok2, aerr2, rdata2);

    // Same checker for the LATENCY=1 instance.
    always @(negedge clk) if (monEn) monitorStep(1, dok1, aok1, aerr1, rdata1);

    // Drive one request for a cycle (called at a falling edge while idle).
    task automatic applyStimulus(input int sel, input logic [31:0] a, input logic r,
                                 input logic w, input logic [31:0] d, input logic [3:0] s,
                                 input bit expectResp, input bit commit);
        exp_t        e;
        logic [3:0]  eff;
        logic [31:0] word;
        int          idx;
        bit          isBad;
        isBad = badAddr(a);
        idx   = int'((a - BASE) >> 2);
`ifdef DMEM_BYTE_STROBE_EN
        eff = s;
`else
        eff = s | 4'b1111;
`endif
        checkOutput($sformatf("ready%0d", sel), {31'b0, (sel == 2) ? aok2 : aok1}, 32'd1);
        if (sel == 2) begin
            addr2 = a; rd2 = r; wr2 = w; wd2 = d;
`ifdef DMEM_BYTE_STROBE_EN
            strb2 = s;
`endif
        end else begin
            addr1 = a; rd1 = r; wr1 = w; wd1 = d;
`ifdef DMEM_BYTE_STROBE_EN
            strb1 = s;
`endif
        end
        e.acceptCyc = cyc;
        e.respCyc   = cyc + ((sel == 2) ? 2 : 1);
        e.err       = isBad;
        e.rdata     = 32'h0;
        if (w) begin
            if (!isBad && commit) begin
                word = (sel == 2) ? m2[idx] : m1[idx];
                for (int b = 0; b < 4; b++)
                    if (eff[b]) word[8*b +: 8] = d[8*b +: 8];
                if (sel == 2) m2[idx] = word; else m1[idx] = word;
            end
        end else if (!isBad) begin
            e.rdata = (sel == 2) ? m2[idx] : m1[idx];
        end
        if (expectResp) begin
            if (sel == 2) q2.push_back(e); else q1.push_back(e);
        end
        @(negedge clk);
        if (sel == 2) begin rd2 = 1'b0; wr2 = 1'b0; end
        else begin rd1 = 1'b0; wr1 = 1'b0; end
    endtask

    // Wait (bounded) at falling edges until the instance is ready again.
    task automatic waitIdle(input int sel);
        int n;
        n = 0;
        while (((sel == 2) ? aok2 : aok1) !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput($sformatf("idleWait%0d", sel), {31'b0, (sel == 2) ? aok2 : aok1}, 32'd1);
    endtask

    task automatic doReq(input int sel, input logic [31:0] a, input logic r, input logic w,
                         input logic [31:0] d, input logic [3:0] s);
        applyStimulus(sel, a, r, w, d, s, 1'b1, 1'b1);
        waitIdle(sel);
    endtask

    initial begin
        rstn2 = 1'b0; rd2 = 1'b1; wr2 = 1'b0; addr2 = BASE; wd2 = 32'h0;
        rstn1 = 1'b0; rd1 = 1'b0; wr1 = 1'b0; addr1 = BASE; wd1 = 32'h0;
`ifdef DMEM_BYTE_STROBE_EN
        strb2 = 4'hF; strb1 = 4'hF;
`endif
        // Reset held two cycles with a read pending.
        @(posedge clk);
        monEn = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput("rstAddrOk", {31'b0, aok2}, 32'd1);
            checkOutput("rstDataOk", {31'b0, dok2}, 32'd0);
            if (i == 0) @(posedge clk);
        end
        rstn2 = 1'b1; rd2 = 1'b0;
        rstn1 = 1'b1;
        repeat (3) @(negedge clk);

        // Write then read-back right after the write response.
        doReq(2, 32'h8000_0010, 1'b0, 1'b1, 32'hDEAD_BEEF, 4'hF);
        doReq(2, 32'h8000_0010, 1'b1, 1'b0, 32'h0, 4'hF);

        // Misaligned write is suppressed; window faults on reads.
        doReq(2, 32'h8000_0012, 1'b0, 1'b1, 32'h0BAD_0BAD, 4'hF);
        doReq(2, 32'h8000_0010, 1'b1, 1'b0, 32'h0, 4'hF);
        doReq(2, 32'h8000_1000, 1'b1, 1'b0, 32'h0, 4'hF);
        doReq(2, 32'h7FFF_FFFC, 1'b1, 1'b0, 32'h0, 4'hF);

        // Last word of the window is legal.
        doReq(2, 32'h8000_0FFC, 1'b0, 1'b1, 32'hA5A5_5A5A, 4'hF);
        doReq(2, 32'h8000_0FFC, 1'b1, 1'b0, 32'h0, 4'hF);

        // Read and write together behave as a write.
        doReq(2, 32'h8000_0020, 1'b1, 1'b1, 32'h1234_5678, 4'hF);
        doReq(2, 32'h8000_0020, 1'b1, 1'b0, 32'h0, 4'hF);

        // Reset during WAIT aborts the write with no response.
        applyStimulus(2, 32'h8000_0010, 1'b0, 1'b1, 32'hCAFE_F00D, 4'hF, 1'b0, 1'b0);
        rstn2 = 1'b0;
        repeat (2) @(negedge clk);
        rstn2 = 1'b1;
        waitIdle(2);
        doReq(2, 32'h8000_0010, 1'b1, 1'b0, 32'h0, 4'hF);

`ifdef DMEM_BYTE_STROBE_EN
        // Byte lanes 0 and 2 only, then an all-zero strobe.
        doReq(2, 32'h8000_0010, 1'b0, 1'b1, 32'h1122_3344, 4'b0101);
        doReq(2, 32'h8000_0010, 1'b1, 1'b0, 32'h0, 4'hF);
        doReq(2, 32'h8000_0010, 1'b0, 1'b1, 32'hFFFF_FFFF, 4'b0000);
        doReq(2, 32'h8000_0010, 1'b1, 1'b0, 32'h0, 4'hF);
`endif

        // LATENCY=1 instance: response one cycle after accept.
        doReq(1, 32'h8000_0040, 1'b0, 1'b1, 32'h55AA_33CC, 4'hF);
        doReq(1, 32'h8000_0040, 1'b1, 1'b0, 32'h0, 4'hF);
        // Reset on the RESP edge: the pulse is seen but the write is dropped.
        applyStimulus(1, 32'h8000_0040, 1'b0, 1'b1, 32'hCAFE_F00D, 4'hF, 1'b1, 1'b0);
        rstn1 = 1'b0;
        repeat (2) @(negedge clk);
        rstn1 = 1'b1;
        waitIdle(1);
        doReq(1, 32'h8000_0040, 1'b1, 1'b0, 32'h0, 4'hF);
        doReq(1, 32'h8000_0041, 1'b1, 1'b0, 32'h0, 4'hF);

        repeat (4) @(negedge clk);
        checkOutput("drain2", q2.size(), 32'd0);
        checkOutput("drain1", q1.size(), 32'd0);
        monEn = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
